// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite draw engine: screen geometry,
// colour width, transparency key, FSM state/mode enums and the address
// helpers used by the draw sequencer.
package draw_pkg;

  localparam int SPRITE_W = 8;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 9;
  localparam int ADDR_W   = 17;
  localparam int CNT_W    = 6;

  localparam logic [COLOUR_W-1:0] KEY_COLOUR = 9'h000;
  localparam logic [CNT_W-1:0]    LAST_PIXEL = CNT_W'(SPRITE_W * SPRITE_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAW,
    FLUSH,
    DONE
  } draw_state_t;

  typedef enum logic {
    MODE_CHAR,
    MODE_BG
  } draw_mode_t;

  // One pixel of the sprite box as it travels down the address/plot pipeline.
  typedef struct packed {
    logic       valid;
    logic       in_screen;
    logic [8:0] x;
    logic [7:0] y;
  } pixel_t;

  // Screen position of pixel idx (row-major) inside the box at (x0, y0).
  // Sums are widened by one bit so the on-screen test sees the true value.
  function automatic pixel_t pixel_at(logic [8:0] x0, logic [7:0] y0,
                                      logic [CNT_W-1:0] idx);
    logic [9:0] x;
    logic [8:0] y;
    x = {1'b0, x0} + {7'b0, idx[2:0]};
    y = {1'b0, y0} + {6'b0, idx[5:3]};
    pixel_at.valid     = 1'b1;
    pixel_at.in_screen = (x < 10'(SCREEN_W)) && (y < 9'(SCREEN_H));
    pixel_at.x         = x[8:0];
    pixel_at.y         = y[7:0];
  endfunction

  // y*320 + x built from two shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] bg_address(logic [8:0] x, logic [7:0] y);
    return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/sprite_draw_fsm_if.sv
// Synchronous ROM read bus (address out, data back one cycle later).
// Used between the sequencer and its char ROM, and available to model the
// external background ROM with the same timing.
interface sprite_draw_fsm_if
  import draw_pkg::*;
#(
  parameter int AW = ADDR_W
) ();

  logic [AW-1:0]       addr;
  logic [COLOUR_W-1:0] data;

  modport master (output addr, input data);
  modport slave  (input addr, output data);

endinterface

// File: rtl/sprite_rom.sv
// 64 x 9 character bitmap with a registered read port (1-cycle latency),
// so char pixels line up with the external background ROM.
// Every seventh texel holds KEY_COLOUR so the SPRITE_TRANSPARENCY_EN build
// has transparent pixels to drop.
module sprite_rom
  import draw_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  sprite_draw_fsm_if.slave  rom
);

  function automatic logic [COLOUR_W-1:0] bitmap(logic [CNT_W-1:0] idx);
    if ((idx % 6'd7) == 6'd0) return KEY_COLOUR;
    return COLOUR_W'(idx) * 9'd7 + 9'd1;
  endfunction

  // Registered read of the constant bitmap.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: the contents are a constant function, so only the output register
    // exists and it is reset; a RAM-backed table would not be reset here.
    if (!resetn) begin
      rom.data <= '0;
    end else begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      rom.data <= bitmap(rom.addr[CNT_W-1:0]);
    end
  end

endmodule

// File: rtl/sprite_draw_fsm.sv
// Sprite box draw sequencer: walks an 8x8 box row-major, issues the ROM
// address for each pixel, then plots it one cycle later when the ROM data
// is back. Draws either the character bitmap or the saved background.
// Optional feature: define SPRITE_TRANSPARENCY_EN to skip char pixels whose
// colour equals KEY_COLOUR (timing is unchanged).
module sprite_draw_fsm
  import draw_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawChar,
  input  logic                drawBG,
  input  logic [8:0]          xCoordinate,
  input  logic [7:0]          yCoordinate,
  output logic [ADDR_W-1:0]   bgAddr,
  input  logic [COLOUR_W-1:0] bgColour,
  output logic [8:0]          vgaX,
  output logic [7:0]          vgaY,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                doneChar,
  output logic                doneBG
);

  draw_state_t         state;
  draw_mode_t          mode;
  logic [8:0]          box_x;
  logic [7:0]          box_y;
  logic [CNT_W-1:0]    cnt;
  pixel_t              issue_pix;   // pixel whose address is on the ROM bus
  pixel_t              plot_pix;    // pixel whose data is back from the ROM
  pixel_t              next_pix;
  logic [ADDR_W-1:0]   bg_addr_q;
  logic [ADDR_W-1:0]   next_addr;
  logic                done_char_q;
  logic                done_bg_q;
  logic                req_latched;
  logic [COLOUR_W-1:0] char_colour;
  logic [COLOUR_W-1:0] pix_colour;
  logic                keyed;

  // Character bitmap: addressed directly by the pixel counter.
  sprite_draw_fsm_if #(.AW(CNT_W)) char_bus ();

  assign char_bus.addr = cnt;
  assign char_colour   = char_bus.data;

  sprite_rom u_sprite_rom (
    .clock  (clock),
    .resetn (resetn),
    .rom    (char_bus)
  );

  // The request that started the current draw; the other one is ignored
  // until the FSM is back in IDLE.
  assign req_latched = (mode == MODE_BG) ? drawBG : drawChar;

  // Next pixel to issue: pixel 0 straight from the coordinate inputs while
  // in LOAD, otherwise the successor of the current count from the latched box.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    next_pix  = '0;
    next_addr = '0;
    if (state == LOAD) begin
      next_pix = pixel_at(xCoordinate, yCoordinate, '0);
    end else begin
      next_pix = pixel_at(box_x, box_y, cnt + CNT_W'(1));
    end
    if ((mode == MODE_BG) && next_pix.in_screen) begin
      next_addr = bg_address(next_pix.x, next_pix.y);
    end
  end

  // Draw sequencer: state, counter, address stage, plot stage and done flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      mode        <= MODE_CHAR;
      box_x       <= '0;
      box_y       <= '0;
      cnt         <= '0;
      issue_pix   <= '0;
      plot_pix    <= '0;
      bg_addr_q   <= '0;
      done_char_q <= 1'b0;
      done_bg_q   <= 1'b0;
    end else begin
      // The plot stage always trails the address stage by one cycle,
      // which is exactly the ROM read latency.
      plot_pix <= issue_pix;

      case (state)
        IDLE: begin
          if (drawBG || drawChar) begin
            mode  <= drawBG ? MODE_BG : MODE_CHAR;
            state <= LOAD;
          end
        end

        LOAD: begin
          box_x     <= xCoordinate;
          box_y     <= yCoordinate;
          cnt       <= '0;
          issue_pix <= next_pix;
          bg_addr_q <= next_addr;
          state     <= DRAW;
        end

        DRAW: begin
          if (cnt == LAST_PIXEL) begin
            issue_pix <= '0;
            bg_addr_q <= '0;
            state     <= FLUSH;
          end else begin
            cnt       <= cnt + CNT_W'(1);
            issue_pix <= next_pix;
            bg_addr_q <= next_addr;
          end
        end

        FLUSH: begin
          // Last pixel is being plotted this cycle.
          done_bg_q   <= (mode == MODE_BG);
          done_char_q <= (mode == MODE_CHAR);
          state       <= DONE;
        end

        DONE: begin
          if (!req_latched) begin
            done_bg_q   <= 1'b0;
            done_char_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPRITE_TRANSPARENCY_EN
  assign keyed = (mode == MODE_CHAR) && (char_colour == KEY_COLOUR);
`else
  assign keyed = 1'b0;
`endif

  assign pix_colour = (mode == MODE_BG) ? bgColour : char_colour;

  assign bgAddr   = bg_addr_q;
  assign vgaX     = plot_pix.x;
  assign vgaY     = plot_pix.y;
  assign colour   = plot_pix.valid ? pix_colour : '0;
  assign plot     = plot_pix.valid && plot_pix.in_screen && !keyed;
  assign doneChar = done_char_q;
  assign doneBG   = done_bg_q;

endmodule
